// File: rtl/memwb_writeback_stage.sv
// MEM/WB pipeline register and load-result formatter for the 5-stage MIPS core.
// Produces the write-back tuple (rd, data, per-byte enable) and the EX/MEM forwardability mask.
module memwb_writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [ADDR_WIDTH-1:0] exmem_rd_addr,
  input  logic [DATA_WIDTH-1:0] exmem_alu_result,
  input  logic [2:0]            exmem_load_op,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [3:0]            exmem_byte_en,
  output logic [ADDR_WIDTH-1:0] memwb_rd_addr,
  output logic [DATA_WIDTH-1:0] memwb_data,
  output logic [3:0]            memwb_byte_en
);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_LB   = 3'b010;
  localparam logic [2:0] OP_LBU  = 3'b011;
  localparam logic [2:0] OP_LH   = 3'b100;
  localparam logic [2:0] OP_LHU  = 3'b101;
  localparam logic [2:0] OP_LWL  = 3'b110;
  localparam logic [2:0] OP_LWR  = 3'b111;

  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]            load_op_q, load_op_d;
  logic [1:0]            offset_q, offset_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  held_q, held_d;

  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [DATA_WIDTH-1:0] fmt_data;
  logic [3:0]            fmt_be;

  // Load results are not known until MEM/WB, so only plain ALU writes may forward.
  always_comb begin
    exmem_byte_en = 4'b0000;
    if (exmem_reg_write && (exmem_rd_addr != '0) && (exmem_load_op == OP_NONE)) begin
      exmem_byte_en = 4'b1111;
    end
  end

  always_comb begin
    reg_write_d = reg_write_q;
    rd_addr_d   = rd_addr_q;
    load_op_d   = load_op_q;
    offset_d    = offset_q;
    result_d    = result_q;
    if (flush) begin
      reg_write_d = 1'b0;
      rd_addr_d   = '0;
      load_op_d   = OP_NONE;
      offset_d    = 2'b00;
      result_d    = '0;
    end else if (!stall) begin
      reg_write_d = exmem_reg_write;
      rd_addr_d   = exmem_rd_addr;
      load_op_d   = exmem_load_op;
      offset_d    = exmem_alu_result[1:0];
      result_d    = exmem_alu_result;
    end
  end

  // The RAM word is only valid in the first MEM/WB cycle; keep it for the rest of a stall.
  always_comb begin
    held_d  = stall && !flush;
    rdata_d = rdata_q;
    if (stall && !flush && !held_q) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      load_op_q   <= OP_NONE;
      offset_q    <= 2'b00;
      result_q    <= '0;
      rdata_q     <= '0;
      held_q      <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      load_op_q   <= load_op_d;
      offset_q    <= offset_d;
      result_q    <= result_d;
      rdata_q     <= rdata_d;
      held_q      <= held_d;
    end
  end

  assign rd_word = held_q ? rdata_q : mem_rdata;

  always_comb begin
    sel_byte = 8'h00;
    case (offset_q)
      2'd0: sel_byte = rd_word[7:0];
      2'd1: sel_byte = rd_word[15:8];
      2'd2: sel_byte = rd_word[23:16];
      2'd3: sel_byte = rd_word[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half = offset_q[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    fmt_data = result_q;
    fmt_be   = 4'b1111;
    case (load_op_q)
      OP_NONE: fmt_data = result_q;
      OP_LW:   fmt_data = rd_word;
      OP_LB:   fmt_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
      OP_LBU:  fmt_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
      OP_LH:   fmt_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
      OP_LHU:  fmt_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
      OP_LWL: begin
        // Memory bytes land in the upper lanes; lower lanes keep the old register value.
        fmt_data = rd_word << {(2'd3 - offset_q), 3'b000};
        case (offset_q)
          2'd0: fmt_be = 4'b1000;
          2'd1: fmt_be = 4'b1100;
          2'd2: fmt_be = 4'b1110;
          default: fmt_be = 4'b1111;
        endcase
      end
      OP_LWR: begin
        fmt_data = rd_word >> {offset_q, 3'b000};
        case (offset_q)
          2'd0: fmt_be = 4'b1111;
          2'd1: fmt_be = 4'b0111;
          2'd2: fmt_be = 4'b0011;
          default: fmt_be = 4'b0001;
        endcase
      end
      default: fmt_data = result_q;
    endcase
  end

  assign memwb_rd_addr = rd_addr_q;
  assign memwb_data    = fmt_data;
  assign memwb_byte_en = (reg_write_q && (rd_addr_q != '0)) ? fmt_be : 4'b0000;

endmodule

// File: tb/tb_memwb_writeback_stage.sv
// Self-checking bench for memwb_writeback_stage: scoreboarded instruction stream
// plus directed stall, flush, rd=0 and asynchronous-reset cases.
module tb_memwb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd_addr;
  logic [31:0] exmem_alu_result;
  logic [2:0]  exmem_load_op;
  logic [31:0] mem_rdata;
  logic [3:0]  exmem_byte_en;
  logic [4:0]  memwb_rd_addr;
  logic [31:0] memwb_data;
  logic [3:0]  memwb_byte_en;

  memwb_writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .exmem_reg_write  (exmem_reg_write),
    .exmem_rd_addr    (exmem_rd_addr),
    .exmem_alu_result (exmem_alu_result),
    .exmem_load_op    (exmem_load_op),
    .mem_rdata        (mem_rdata),
    .exmem_byte_en    (exmem_byte_en),
    .memwb_rd_addr    (memwb_rd_addr),
    .memwb_data       (memwb_data),
    .memwb_byte_en    (memwb_byte_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [2:0]  op;
    logic [31:0] rdata;
  } instr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_t;

  instr_t prog[$];
  wb_t    sb[$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte-array reference for the load formatter.
  function automatic wb_t model(input instr_t in);
    wb_t         r;
    logic [7:0]  b [4];
    logic [15:0] h;
    int          a;
    for (int i = 0; i < 4; i++) b[i] = in.rdata[8*i +: 8];
    a      = int'(in.res[1:0]);
    h      = (a >= 2) ? {b[3], b[2]} : {b[1], b[0]};
    r.rd   = in.rd;
    r.data = 32'h0;
    r.be   = 4'hF;
    case (in.op)
      3'd0: r.data = in.res;
      3'd1: r.data = in.rdata;
      3'd2: r.data = {{24{b[a][7]}}, b[a]};
      3'd3: r.data = {24'h0, b[a]};
      3'd4: r.data = {{16{h[15]}}, h};
      3'd5: r.data = {16'h0, h};
      3'd6: begin
        r.be = 4'h0;
        for (int i = 0; i < 4; i++)
          if (i >= 3 - a) begin
            r.data[8*i +: 8] = b[i-(3-a)];
            r.be[i] = 1'b1;
          end
      end
      default: begin
        r.be = 4'h0;
        for (int i = 0; i < 4; i++)
          if (i <= 3 - a) begin
            r.data[8*i +: 8] = b[i+a];
            r.be[i] = 1'b1;
          end
      end
    endcase
    if (!in.rw || in.rd == 5'd0) r.be = 4'h0;
    return r;
  endfunction

  function automatic logic [3:0] exp_fwd(input logic rw, input logic [4:0] rd, input logic [2:0] op);
    return (rw && rd != 5'd0 && op == 3'd0) ? 4'hF : 4'h0;
  endfunction

  task automatic add(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                     input logic [2:0] op, input logic [31:0] rdata);
    instr_t t;
    t.rw = rw; t.rd = rd; t.res = res; t.op = op; t.rdata = rdata;
    prog.push_back(t);
  endtask

  task automatic set_ex(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                        input logic [2:0] op);
    exmem_reg_write  = rw;
    exmem_rd_addr    = rd;
    exmem_alu_result = res;
    exmem_load_op    = op;
  endtask

  initial begin
    wb_t    e;
    instr_t cur;
    int     n;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; mem_rdata = 32'h0;
    set_ex(1'b0, 5'd0, 32'h0, 3'd0);
    #2;
    check("rst_rd", 32'(memwb_rd_addr), 32'h0);
    check("rst_data", memwb_data, 32'h0);
    check("rst_be", 32'(memwb_byte_en), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    add(1'b1, 5'd5,  32'h12345678, 3'd0, 32'h0);
    add(1'b1, 5'd5,  32'h12345678, 3'd1, 32'h5A5A0001);
    add(1'b1, 5'd8,  32'h00001003, 3'd2, 32'h80AABBCC);
    add(1'b1, 5'd8,  32'h00001003, 3'd3, 32'h80AABBCC);
    add(1'b1, 5'd9,  32'h00002002, 3'd5, 32'h80AABBCC);
    add(1'b1, 5'd9,  32'h00002003, 3'd4, 32'h80AABBCC);
    add(1'b1, 5'd10, 32'h00000000, 3'd4, 32'h12347FFF);
    add(1'b1, 5'd11, 32'h00000001, 3'd6, 32'hDDCCBBAA);
    add(1'b1, 5'd12, 32'h00000002, 3'd7, 32'hDDCCBBAA);
    add(1'b1, 5'd13, 32'h00000000, 3'd6, 32'h44332211);
    add(1'b1, 5'd13, 32'h00000003, 3'd6, 32'h44332211);
    add(1'b1, 5'd14, 32'h00000000, 3'd7, 32'h44332211);
    add(1'b1, 5'd14, 32'h00000003, 3'd7, 32'h44332211);
    add(1'b1, 5'd0,  32'hFEEDFACE, 3'd0, 32'h0);
    add(1'b0, 5'd15, 32'hFEEDFACE, 3'd1, 32'h11111111);
    for (int i = 0; i < 24; i++)
      add(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          3'($urandom_range(0, 7)), $urandom);

    n = prog.size();
    for (int k = 0; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k < n) begin
        cur = prog[k];
        set_ex(cur.rw, cur.rd, cur.res, cur.op);
      end else begin
        set_ex(1'b0, 5'd0, 32'h0, 3'd0);
      end
      mem_rdata = (k > 0) ? prog[k-1].rdata : 32'h0;
      @(negedge clk);
      if (k < n) check("ex_fwd", 32'(exmem_byte_en), 32'(exp_fwd(cur.rw, cur.rd, cur.op)));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wb_rd", 32'(memwb_rd_addr), 32'(e.rd));
        check("wb_be", 32'(memwb_byte_en), 32'(e.be));
        if (e.be != 4'h0) check("wb_data", memwb_data, e.data);
      end
      if (k < n) sb.push_back(model(cur));
    end
    check("sb_empty", 32'(sb.size()), 32'h0);

    // Stall holds the captured LW data while the RAM output moves on.
    @(posedge clk); #1;
    set_ex(1'b1, 5'd7, 32'h00000100, 3'd1);
    mem_rdata = 32'h0;
    @(posedge clk); #1;
    set_ex(1'b1, 5'd9, 32'h00000055, 3'd0);
    mem_rdata = 32'hCAFEF00D;
    stall = 1'b1;
    @(negedge clk);
    check("stl_data0", memwb_data, 32'hCAFEF00D);
    check("stl_be0", 32'(memwb_byte_en), 32'hF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_rdata = 32'hDEADBEEF;
      if (i == 2) stall = 1'b0;
      @(negedge clk);
      check("stl_data", memwb_data, 32'hCAFEF00D);
      check("stl_rd", 32'(memwb_rd_addr), 32'd7);
    end
    @(posedge clk); #1;
    set_ex(1'b0, 5'd0, 32'h0, 3'd0);
    @(negedge clk);
    check("stl_next_rd", 32'(memwb_rd_addr), 32'd9);
    check("stl_next_data", memwb_data, 32'h00000055);
    check("stl_next_be", 32'(memwb_byte_en), 32'hF);

    // Flush wins over stall; a write to r0 never enables bytes.
    @(posedge clk); #1;
    set_ex(1'b1, 5'd3, 32'h000000A5, 3'd0);
    @(posedge clk); #1;
    set_ex(1'b1, 5'd6, 32'h00000066, 3'd0);
    stall = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("fl_pre_be", 32'(memwb_byte_en), 32'hF);
    check("fl_pre_data", memwb_data, 32'h000000A5);
    @(posedge clk); #1;
    stall = 1'b0; flush = 1'b0;
    set_ex(1'b1, 5'd0, 32'h00000077, 3'd0);
    @(negedge clk);
    check("fl_be", 32'(memwb_byte_en), 32'h0);
    check("fl_rd", 32'(memwb_rd_addr), 32'h0);
    check("r0_fwd", 32'(exmem_byte_en), 32'h0);
    @(posedge clk); #1;
    set_ex(1'b1, 5'd4, 32'h00000099, 3'd0);
    @(negedge clk);
    check("r0_be", 32'(memwb_byte_en), 32'h0);

    // Asynchronous reset mid-stall clears outputs at once; forwarding mask stays combinational.
    @(posedge clk); #1;
    stall = 1'b1;
    mem_rdata = 32'h13579BDF;
    @(negedge clk);
    check("ar_pre_be", 32'(memwb_byte_en), 32'hF);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("ar_rd", 32'(memwb_rd_addr), 32'h0);
    check("ar_data", memwb_data, 32'h0);
    check("ar_be", 32'(memwb_byte_en), 32'h0);
    check("ar_fwd", 32'(exmem_byte_en), 32'hF);
    @(posedge clk); #1;
    check("ar_hold_be", 32'(memwb_byte_en), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    set_ex(1'b1, 5'd2, 32'h0, 3'd1);
    mem_rdata = 32'h0;
    @(posedge clk); #1;
    mem_rdata = 32'h11112222;
    @(negedge clk);
    check("ar_post_data", memwb_data, 32'h11112222);
    check("ar_post_rd", 32'(memwb_rd_addr), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
